clock_set_sequencer: RTL and testbench

Sequences the time/date setting process of the digital clock. Turns two debounced push-buttons (mode, increment) into a registered 3-bit mode select and per-field increment pulses for the hour, minute, day, month and year counters. It also gates normal timekeeping and returns the clock to run mode after a period of button inactivity. It sits between the button debouncers and the counter load/increment control logic.

---
 rtl/clock_set_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_clock_set_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_sequencer.sv
// clock_set_sequencer
//   Turns the debounced mode/increment buttons into a registered 3-bit mode
//   select and one-cycle increment pulses for the hour, minute, day, month
//   and year counters. It gates timekeeping (run) and falls back to RUN after
//   TIMEOUT seconds without a button press.
//
// Build option: define CLOCK_SET_AUTO_REPEAT_EN to enable auto-repeat of the
//   increment button. Without it, each press gives exactly one pulse.
//
// Parameters:
//   REPEAT_DLY - clk cycles inc_btn is held before auto-repeat starts (>=1)
//   REPEAT_PER - clk cycles between auto-repeat pulses (>=1)
//   TIMEOUT    - sec_tick pulses without a press before returning to RUN (>=1)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   sec_tick  in   one-cycle 1 Hz pulse
//   mode_btn  in   debounced mode button level
//   inc_btn   in   debounced increment button level
//   mode      out  current mode {s2,s1,s0}
//   run       out  high only in RUN
//   inc_hour, inc_min, inc_day, inc_mon, inc_year
//             out  one-cycle increment pulses
//   clr_sec   out  one-cycle pulse when leaving SET_MIN
//   blink     out  blink for the field being edited
module clock_set_sequencer #(
    parameter int unsigned REPEAT_DLY = 50,
    parameter int unsigned REPEAT_PER = 10,
    parameter int unsigned TIMEOUT    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [2:0] mode,
    output logic       run,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       inc_day,
    output logic       inc_mon,
    output logic       inc_year,
    output logic       clr_sec,
    output logic       blink
);

    typedef enum logic [2:0] {
        RUN      = 3'b000,
        SET_HOUR = 3'b001,
        SET_MIN  = 3'b010,
        SET_DAY  = 3'b011,
        SET_MON  = 3'b100,
        SET_YEAR = 3'b101
    } mode_e;

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    // Zero delays/periods/timeouts are meaningless; refuse to elaborate them.
    if (REPEAT_DLY < 1 || REPEAT_PER < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("clock_set_sequencer: REPEAT_DLY, REPEAT_PER and TIMEOUT must be >= 1");
    end

    // Mode register is a plain vector so the unused codes 110/111 can be held
    // (e.g. after an upset) and recovered to RUN.
    logic [2:0]    mode_q;
    logic [2:0]    mode_d;
    logic [2:0]    mode_adv;
    logic          mode_prev;
    logic          inc_prev;
    logic          mode_press;
    logic          inc_press;
    logic          in_set;
    logic          legal;
    logic          mode_change;
    logic          timeout_hit;
    logic          rep_fire;
    logic          inc_fire;
    logic          blink_d;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_d;

    always_comb begin
        mode_press  = mode_btn & ~mode_prev;
        inc_press   = inc_btn & ~inc_prev;
        in_set      = 1'b0;
        legal       = 1'b1;
        mode_adv    = RUN;
        case (mode_q)
            RUN:      mode_adv = SET_HOUR;
            SET_HOUR: begin mode_adv = SET_MIN;  in_set = 1'b1; end
            SET_MIN:  begin mode_adv = SET_DAY;  in_set = 1'b1; end
            SET_DAY:  begin mode_adv = SET_MON;  in_set = 1'b1; end
            SET_MON:  begin mode_adv = SET_YEAR; in_set = 1'b1; end
            SET_YEAR: begin mode_adv = RUN;      in_set = 1'b1; end
            default:  legal = 1'b0;
        endcase

        // A press in the same cycle as the final tick wins over the timeout.
        timeout_hit = in_set & sec_tick & ~(mode_press | inc_press)
                    & (tcnt == TW'(TIMEOUT - 1));

        mode_d = mode_q;
        if (!legal)
            mode_d = RUN;
        else if (mode_press)
            mode_d = mode_adv;
        else if (timeout_hit)
            mode_d = RUN;
        mode_change = (mode_d != mode_q);

        tcnt_d = tcnt;
        if (!in_set || mode_press || inc_press || timeout_hit)
            tcnt_d = '0;
        else if (sec_tick)
            tcnt_d = tcnt + TW'(1);

        // Mode advance suppresses any increment in the same cycle.
        inc_fire = in_set & ~mode_press & (inc_press | rep_fire);

        blink_d = blink;
        if (mode_change || !in_set)
            blink_d = 1'b0;
        else if (sec_tick)
            blink_d = ~blink;
    end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RW   = $clog2(RMAX) + 1;

    logic [RW-1:0] rcnt;
    logic          rep_phase;

    // rcnt counts cycles since the press (0 in the press cycle). After the
    // first repeat it restarts at 1 and compares against the period, so it
    // never exceeds max(REPEAT_DLY, REPEAT_PER).
    assign rep_fire = inc_btn & (rep_phase ? (rcnt == RW'(REPEAT_PER))
                                           : (rcnt == RW'(REPEAT_DLY)));

    always_ff @(posedge clk) begin
        if (rst || !inc_btn || mode_change) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
        end else if (rep_fire) begin
            rcnt      <= RW'(1);
            rep_phase <= 1'b1;
        end else begin
            rcnt      <= rcnt + RW'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= RUN;
            run       <= 1'b1;
            inc_hour  <= 1'b0;
            inc_min   <= 1'b0;
            inc_day   <= 1'b0;
            inc_mon   <= 1'b0;
            inc_year  <= 1'b0;
            clr_sec   <= 1'b0;
            blink     <= 1'b0;
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
            tcnt      <= '0;
        end else begin
            mode_q    <= mode_d;
            run       <= (mode_d == RUN);
            inc_hour  <= inc_fire & (mode_q == SET_HOUR);
            inc_min   <= inc_fire & (mode_q == SET_MIN);
            inc_day   <= inc_fire & (mode_q == SET_DAY);
            inc_mon   <= inc_fire & (mode_q == SET_MON);
            inc_year  <= inc_fire & (mode_q == SET_YEAR);
            clr_sec   <= (mode_q == SET_MIN) & mode_change;
            blink     <= blink_d;
            mode_prev <= mode_btn;
            inc_prev  <= inc_btn;
            tcnt      <= tcnt_d;
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_clock_set_sequencer.sv
module tb_clock_set_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick;
    logic       mode_btn;
    logic       inc_btn;
    logic [2:0] mode;
    logic       run;
    logic       inc_hour, inc_min, inc_day, inc_mon, inc_year;
    logic       clr_sec;
    logic       blink;
    logic [4:0] incs;

    int n_tests = 0;
    int n_fail  = 0;
    int multi   = 0;
    int pulses  = 0;

    clock_set_sequencer #(
        .REPEAT_DLY (50),
        .REPEAT_PER (10),
        .TIMEOUT    (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sec_tick (sec_tick),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .mode     (mode),
        .run      (run),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .inc_day  (inc_day),
        .inc_mon  (inc_mon),
        .inc_year (inc_year),
        .clr_sec  (clr_sec),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    assign incs = {inc_hour, inc_min, inc_day, inc_mon, inc_year};

    always @(negedge clk)
        if ($countones(incs) > 1) multi++;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        mode_btn = 1'b1;
        tick();
        mode_btn = 1'b0;
        tick();
    endtask

    task automatic inc_once(input int exp_vec);
        inc_btn = 1'b1;
        tick();
        check("inc_route", int'(incs), exp_vec);
        inc_btn = 1'b0;
        tick();
        check("inc_width", int'(incs), 0);
    endtask

    // One idle cycle, then a one-cycle sec_tick; returns just after the edge
    // that registers that tick.
    task automatic sec_pulse();
        tick();
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_modes[6] = '{1, 2, 3, 4, 5, 0};
        int exp_p;

        rst = 1'b1; sec_tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_mode",  int'(mode), 0);
        check("rst_run",   int'(run), 1);
        check("rst_incs",  int'(incs), 0);
        check("rst_clr",   int'(clr_sec), 0);
        check("rst_blink", int'(blink), 0);

        // Mode cycling, holding each press an extra cycle.
        for (int i = 0; i < 6; i++) begin
            mode_btn = 1'b1;
            tick();
            check("cyc_mode", int'(mode), exp_modes[i]);
            check("cyc_run",  int'(run), int'(exp_modes[i] == 0));
            check("cyc_clr",  int'(clr_sec), int'(i == 2));
            tick();
            check("cyc_hold", int'(mode), exp_modes[i]);
            check("cyc_clr1", int'(clr_sec), 0);
            mode_btn = 1'b0;
            tick();
        end

        // Hold inc in SET_MIN for 80 cycles; release lands on the c+80
        // repeat point, which must not produce a pulse.
        press_mode();
        press_mode();
        check("setmin", int'(mode), 2);
        pulses = 0;
        for (int k = 0; k < 90; k++) begin
            inc_btn = (k < 80);
            tick();
`ifdef CLOCK_SET_AUTO_REPEAT_EN
            exp_p = ((k + 1) == 1 || (k + 1) == 51 || (k + 1) == 61 || (k + 1) == 71) ? 8 : 0;
`else
            exp_p = ((k + 1) == 1) ? 8 : 0;
`endif
            check("rep_incs", int'(incs), exp_p);
            if (inc_min) pulses++;
        end
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        check("rep_count", pulses, 4);
`else
        check("rep_count", pulses, 1);
`endif
        inc_btn = 1'b0;

        // SET_MIN -> SET_HOUR, routing, simultaneous press.
        for (int i = 0; i < 5; i++) press_mode();
        check("sethour", int'(mode), 1);
        inc_once(16);
        mode_btn = 1'b1; inc_btn = 1'b1;
        tick();
        check("sim_mode", int'(mode), 2);
        check("sim_incs", int'(incs), 0);
        mode_btn = 1'b0; inc_btn = 1'b0;
        tick();
        check("sim_incs1", int'(incs), 0);
        inc_once(8);
        press_mode();
        inc_once(4);
        press_mode();
        inc_once(2);
        press_mode();
        inc_once(1);
        press_mode();
        check("run_again", int'(mode), 0);
        inc_once(0);

        // Timeout in SET_DAY with blink toggling.
        for (int i = 0; i < 3; i++) press_mode();
        check("setday", int'(mode), 3);
        for (int j = 1; j <= 10; j++) begin
            sec_pulse();
            if (j < 10) begin
                check("to_mode",  int'(mode), 3);
                check("to_blink", int'(blink), j % 2);
            end else begin
                check("to_end_mode",  int'(mode), 0);
                check("to_end_run",   int'(run), 1);
                check("to_end_blink", int'(blink), 0);
                check("to_end_clr",   int'(clr_sec), 0);
            end
        end

        // Press in the same cycle as the 10th tick restarts the count.
        for (int i = 0; i < 3; i++) press_mode();
        for (int j = 1; j <= 9; j++) sec_pulse();
        check("rs_mode9", int'(mode), 3);
        tick();
        sec_tick = 1'b1; inc_btn = 1'b1;
        tick();
        sec_tick = 1'b0; inc_btn = 1'b0;
        check("rs_prio_mode", int'(mode), 3);
        check("rs_prio_inc",  int'(incs), 4);
        for (int j = 1; j <= 10; j++) begin
            sec_pulse();
            check("rs_mode", int'(mode), (j < 10) ? 3 : 0);
        end

        // Timeout out of SET_MIN clears seconds.
        press_mode();
        press_mode();
        for (int j = 1; j <= 10; j++) sec_pulse();
        check("tomin_mode", int'(mode), 0);
        check("tomin_clr",  int'(clr_sec), 1);
        tick();
        check("tomin_clr1", int'(clr_sec), 0);

        // Illegal code recovers to RUN on the next clock.
        press_mode();
        check("ill_pre", int'(mode), 1);
        force dut.mode_q = 3'b110;
        #8;
        release dut.mode_q;
        @(posedge clk);
        #1;
        check("ill_mode", int'(mode), 0);
        check("ill_run",  int'(run), 1);

        // Buttons held through reset give exactly one press after release.
        press_mode();
        sec_pulse();
        rst = 1'b1; mode_btn = 1'b1; inc_btn = 1'b1;
        tick();
        tick();
        check("rst2_mode",  int'(mode), 0);
        check("rst2_blink", int'(blink), 0);
        rst = 1'b0;
        tick();
        check("rel_mode", int'(mode), 1);
        check("rel_incs", int'(incs), 0);
        tick();
        tick();
        check("rel_hold", int'(mode), 1);
        mode_btn = 1'b0; inc_btn = 1'b0;
        tick();

        check("onehot", multi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
